plic_claim_ctrl: RTL and testbench
==================================

PLIC_CLAIM_CTRL -- requirements
Module: plic_claim_ctrl

Interface
REQ-001 SHALL have parameter SOURCES, default 16, meaning number of interrupt sources (1+).
REQ-002 SHALL have parameter PRIORITIES, default 7, meaning number of priority levels (1+).
REQ-003 SHALL derive SOURCES_BITS = $clog2(SOURCES+1) and PRIORITY_BITS = $clog2(PRIORITIES); ID 0 is reserved for "no interrupt".
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port pending_i, input, SOURCES, gateway pending bits; bit n is ID n+1.
REQ-007 SHALL have port ie_i, input, SOURCES, per-source enable for this target.
REQ-008 SHALL have port priority_i, input, SOURCES x PRIORITY_BITS unpacked array, per-source priority.
REQ-009 SHALL have port threshold_i, input, PRIORITY_BITS, target priority threshold.
REQ-010 SHALL have port claim_i, input, 1, claim request.
REQ-011 SHALL have port claim_rdy_o, output, 1, claim accepted this cycle when high together with claim_i.
REQ-012 SHALL have port claim_id_o, output, SOURCES_BITS, ID returned by an accepted claim.
REQ-013 SHALL have port claim_vld_o, output, 1, one-cycle pulse qualifying claim_id_o.
REQ-014 SHALL have port complete_i, input, 1, completion strobe.
REQ-015 SHALL have port complete_id_i, input, SOURCES_BITS, ID being completed.
REQ-016 SHALL have port ireq_o, output, 1, interrupt request to the hart.
REQ-017 SHALL have port id_o, output, SOURCES_BITS, registered ID of the best candidate.

Function
REQ-018 Candidate n SHALL be pending_i[n] & ie_i[n] & ~claimed[n] & (priority_i[n] != 0).
REQ-019 Arbitration SHALL select the candidate with the highest priority; ties go to the lowest ID; no candidate yields ID 0, priority 0.
REQ-020 Arbitration result (ID, priority) SHALL be registered: 1-cycle latency from input change to id_o.
REQ-021 ireq_o SHALL be high iff state is ARB and registered priority > threshold_i (unsigned compare, PRIORITY_BITS wide).
REQ-022 FSM states: ARB, SETTLE. Reset state ARB.
REQ-023 ARB -> SETTLE on an accepted claim (claim_i & claim_rdy_o) or on an effective complete (REQ-027); otherwise stay ARB.
REQ-024 SETTLE -> ARB unconditionally after exactly one cycle; in SETTLE ireq_o = 0 and claim_rdy_o = 0.
REQ-025 claim_rdy_o SHALL equal (state == ARB).
REQ-026 Accepted claim: next cycle claim_vld_o = 1, claim_id_o = registered ID if ireq_o was high, else 0; when ID != 0, claimed[ID-1] sets.
REQ-027 Complete SHALL be effective only when complete_id_i in 1..SOURCES and claimed[complete_id_i-1] = 1; it clears that bit; other completes ignored, no state change.
REQ-028 Claim and complete in the same cycle SHALL both apply; a complete targeting the ID being claimed that cycle is ignored (bit not yet set).
REQ-029 complete_i SHALL be accepted in either state (never back-pressured).
REQ-030 claim_vld_o SHALL be low in all cycles other than the one after an accepted claim; claim_id_o holds its last value.

Reset
REQ-031 rst_i high at a clock edge SHALL force: state ARB, claimed all 0, registered ID/priority 0, ireq_o 0, id_o 0, claim_vld_o 0, claim_id_o 0, claim_rdy_o 1 the next cycle.
REQ-032 Reset asserted mid-claim or in SETTLE SHALL discard the in-flight claim; no claim_vld_o pulse follows.

Configuration
REQ-033 Macro PLIC_CLAIM_MASK_EN defined: claimed[] tracking per REQ-018/026/027 included.
REQ-034 Macro PLIC_CLAIM_MASK_EN undefined: claimed[] removed (treated as all 0), complete_i still triggers SETTLE when complete_id_i in 1..SOURCES, else ignored.

Verification
REQ-035 SOURCES=16, PRIORITIES=7, threshold 0, sources 3 (prio 2) and 9 (prio 5) pending+enabled -> id_o = 10 and ireq_o = 1 one cycle later.
REQ-036 Sources 4 and 7 both prio 3 -> id_o = 5 (lowest ID wins); threshold set to 3 -> ireq_o = 0, id_o stays 5.
REQ-037 Claim with id_o = 10 -> claim_vld_o pulse with claim_id_o = 10, one SETTLE cycle (claim_rdy_o = 0, ireq_o = 0), then id_o = 4 (next best); with macro undefined, id_o returns to 10.
REQ-038 Claim while ireq_o = 0 -> claim_id_o = 0, claimed unchanged; complete_id_i = 0 or 17 or unclaimed ID -> no SETTLE, no state change.
REQ-039 Simultaneous claim of ID 10 and complete of previously claimed ID 4 -> claimed[9] = 1, claimed[3] = 0, one SETTLE cycle.
REQ-040 rst_i asserted in SETTLE after a claim -> all outputs per REQ-031, no claim_vld_o pulse, claimed cleared.

Source files
------------

// File: rtl/plic_claim_ctrl.sv
// PLIC target claim/complete controller with a registered priority arbiter.
// Define PLIC_CLAIM_MASK_EN to mask claimed sources until they are completed.
module plic_claim_ctrl #(
    parameter int SOURCES    = 16,
    parameter int PRIORITIES = 7,
    localparam int SOURCES_BITS  = $clog2(SOURCES + 1),
    localparam int PRIORITY_BITS = $clog2(PRIORITIES)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [SOURCES-1:0]       pending_i,
    input  logic [SOURCES-1:0]       ie_i,
    input  logic [PRIORITY_BITS-1:0] priority_i [SOURCES],
    input  logic [PRIORITY_BITS-1:0] threshold_i,
    input  logic                     claim_i,
    output logic                     claim_rdy_o,
    output logic [SOURCES_BITS-1:0]  claim_id_o,
    output logic                     claim_vld_o,
    input  logic                     complete_i,
    input  logic [SOURCES_BITS-1:0]  complete_id_i,
    output logic                     ireq_o,
    output logic [SOURCES_BITS-1:0]  id_o
);

    typedef enum logic {ARB, SETTLE} state_e;

    state_e                   state_q, state_d;
    logic [SOURCES_BITS-1:0]  best_id_q, best_id_d;
    logic [PRIORITY_BITS-1:0] best_prio_q, best_prio_d;
    logic                     claim_vld_q, claim_vld_d;
    logic [SOURCES_BITS-1:0]  claim_id_q, claim_id_d;
    logic [SOURCES-1:0]       claimed;
    logic [SOURCES-1:0]       complete_hit;
    logic                     claim_accept;
    logic                     complete_eff;

`ifdef PLIC_CLAIM_MASK_EN
    logic [SOURCES-1:0] claimed_q, claimed_d;
    logic [SOURCES-1:0] claim_hit;
    assign claimed = claimed_q;
`else
    assign claimed = '0;
`endif

    assign claim_rdy_o  = (state_q == ARB);
    assign ireq_o       = (state_q == ARB) && (best_prio_q > threshold_i);
    assign claim_accept = claim_i && claim_rdy_o;
    assign id_o         = best_id_q;
    assign claim_vld_o  = claim_vld_q;
    assign claim_id_o   = claim_id_q;

    // Ascending scan with strict compare keeps the lowest ID on priority ties.
    always_comb begin
        best_id_d   = '0;
        best_prio_d = '0;
        for (int n = 0; n < SOURCES; n++) begin
            if (pending_i[n] && ie_i[n] && !claimed[n] &&
                (priority_i[n] != '0) && (priority_i[n] > best_prio_d)) begin
                best_id_d   = SOURCES_BITS'(n + 1);
                best_prio_d = priority_i[n];
            end
        end
    end

    // One-hot decode of the completed ID; IDs outside 1..SOURCES never hit.
    always_comb begin
        complete_hit = '0;
        for (int n = 0; n < SOURCES; n++) begin
            complete_hit[n] = (complete_id_i == SOURCES_BITS'(n + 1));
        end
    end

    always_comb begin
        claim_vld_d = claim_accept;
        claim_id_d  = claim_id_q;
        if (claim_accept) begin
            claim_id_d = ireq_o ? best_id_q : '0;
        end
    end

`ifdef PLIC_CLAIM_MASK_EN
    assign complete_eff = complete_i && (|(complete_hit & claimed_q));

    always_comb begin
        claim_hit = '0;
        for (int n = 0; n < SOURCES; n++) begin
            claim_hit[n] = claim_accept && (claim_id_d == SOURCES_BITS'(n + 1));
        end
        claimed_d = claimed_q;
        if (complete_eff) begin
            claimed_d = claimed_d & ~complete_hit;
        end
        claimed_d = claimed_d | claim_hit;
    end
`else
    assign complete_eff = complete_i && (|complete_hit);
`endif

    always_comb begin
        state_d = ARB;
        if (state_q == ARB && (claim_accept || complete_eff)) begin
            state_d = SETTLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB;
            best_id_q   <= '0;
            best_prio_q <= '0;
            claim_vld_q <= 1'b0;
            claim_id_q  <= '0;
`ifdef PLIC_CLAIM_MASK_EN
            claimed_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            claim_vld_q <= claim_vld_d;
            claim_id_q  <= claim_id_d;
`ifdef PLIC_CLAIM_MASK_EN
            claimed_q   <= claimed_d;
`endif
        end
    end

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Self-checking bench for plic_claim_ctrl: directed scenarios plus random
// traffic compared every cycle against a behavioural claim/complete model.
module tb_plic_claim_ctrl;

    localparam int SOURCES = 16;
    localparam int PRIORITIES = 7;
    localparam int SB = 5;
    localparam int PB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   pending;
    logic [15:0]   ie;
    logic [PB-1:0] prio [SOURCES];
    logic [PB-1:0] threshold;
    logic          claim;
    logic          complete;
    logic [SB-1:0] complete_id;
    logic          claim_rdy;
    logic          claim_vld;
    logic          ireq;
    logic [SB-1:0] claim_id;
    logic [SB-1:0] id;

    int checks = 0;
    int failures = 0;

    bit        m_settle = 1'b0;
    bit [15:0] m_claimed = '0;
    int        m_id = 0;
    int        m_prio = 0;
    bit        m_vld = 1'b0;
    int        m_cid = 0;

    always #5 clk = ~clk;

    plic_claim_ctrl #(
        .SOURCES(SOURCES),
        .PRIORITIES(PRIORITIES)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .pending_i(pending),
        .ie_i(ie),
        .priority_i(prio),
        .threshold_i(threshold),
        .claim_i(claim),
        .claim_rdy_o(claim_rdy),
        .claim_id_o(claim_id),
        .claim_vld_o(claim_vld),
        .complete_i(complete),
        .complete_id_i(complete_id),
        .ireq_o(ireq),
        .id_o(id)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Model: best = highest priority present, then lowest ID holding it.
    task automatic modelStep();
        bit        acc;
        bit        eff;
        bit        ireq_now;
        int        cid;
        int        cidx;
        int        nid;
        int        nprio;
        bit [15:0] next_claimed;
        if (rst) begin
            m_settle = 1'b0;
            m_claimed = '0;
            m_id = 0;
            m_prio = 0;
            m_vld = 1'b0;
            m_cid = 0;
            return;
        end
        nid = 0;
        nprio = 0;
        for (int p = (1 << PB) - 1; p >= 1 && nid == 0; p--) begin
            for (int n = 0; n < SOURCES && nid == 0; n++) begin
                if (pending[n] && ie[n] && !m_claimed[n] && int'(prio[n]) == p) begin
                    nid = n + 1;
                    nprio = p;
                end
            end
        end
        acc = claim && !m_settle;
        ireq_now = !m_settle && (m_prio > int'(threshold));
        cid = ireq_now ? m_id : 0;
        cidx = int'(complete_id);
`ifdef PLIC_CLAIM_MASK_EN
        eff = complete && cidx >= 1 && cidx <= SOURCES && m_claimed[cidx-1];
`else
        eff = complete && cidx >= 1 && cidx <= SOURCES;
`endif
        next_claimed = m_claimed;
`ifdef PLIC_CLAIM_MASK_EN
        if (eff) next_claimed[cidx-1] = 1'b0;
        if (acc && cid != 0) next_claimed[cid-1] = 1'b1;
`endif
        m_claimed = next_claimed;
        m_id = nid;
        m_prio = nprio;
        m_vld = acc;
        if (acc) m_cid = cid;
        m_settle = !m_settle && (acc || eff);
    endtask

    always @(posedge clk) begin
        modelStep();
        #1;
        checkOutput("claim_rdy", int'(claim_rdy), int'(!m_settle));
        checkOutput("ireq", int'(ireq), int'(!m_settle && (m_prio > int'(threshold))));
        checkOutput("id", int'(id), m_id);
        checkOutput("claim_vld", int'(claim_vld), int'(m_vld));
        checkOutput("claim_id", int'(claim_id), m_cid);
    end

    task automatic clearSources();
        pending = '0;
        ie = '0;
        for (int n = 0; n < SOURCES; n++) prio[n] = '0;
    endtask

    task automatic setSource(input int n, input int p);
        pending[n] = 1'b1;
        ie[n] = 1'b1;
        prio[n] = PB'(p);
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin
            pending = 16'($urandom);
            ie = 16'($urandom | $urandom);
        end
        if ($urandom_range(0, 7) == 0) begin
            prio[$urandom_range(0, SOURCES - 1)] = PB'($urandom_range(0, 7));
        end
        if ($urandom_range(0, 15) == 0) threshold = PB'($urandom_range(0, 4));
        claim = ($urandom_range(0, 3) == 0);
        complete = ($urandom_range(0, 2) == 0);
        complete_id = ($urandom_range(0, 9) == 0) ? SB'($urandom_range(0, 31))
                                                  : SB'($urandom_range(1, SOURCES));
        rst = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        rst = 1'b1;
        clearSources();
        threshold = '0;
        claim = 1'b0;
        complete = 1'b0;
        complete_id = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_claim_rdy", int'(claim_rdy), 1);
        checkOutput("rst_ireq", int'(ireq), 0);
        checkOutput("rst_id", int'(id), 0);
        checkOutput("rst_claim_vld", int'(claim_vld), 0);
        checkOutput("rst_claim_id", int'(claim_id), 0);

        // Two candidates, higher priority wins.
        setSource(3, 2);
        setSource(9, 5);
        @(negedge clk);
        checkOutput("best_id", int'(id), 10);
        checkOutput("best_ireq", int'(ireq), 1);
        checkOutput("model_best_id", m_id, 10);
        checkOutput("model_best_prio", m_prio, 5);

        // Equal priorities: lowest ID wins; threshold equal to priority masks ireq.
        clearSources();
        setSource(4, 3);
        setSource(7, 3);
        @(negedge clk);
        checkOutput("tie_id", int'(id), 5);
        checkOutput("tie_ireq", int'(ireq), 1);
        threshold = 3'd3;
        @(negedge clk);
        checkOutput("thr_ireq", int'(ireq), 0);
        checkOutput("thr_id", int'(id), 5);

        // Claim while ireq low returns ID 0.
        claim = 1'b1;
        @(negedge clk);
        claim = 1'b0;
        checkOutput("noirq_vld", int'(claim_vld), 1);
        checkOutput("noirq_cid", int'(claim_id), 0);
        checkOutput("noirq_settle_rdy", int'(claim_rdy), 0);
        @(negedge clk);
        checkOutput("noirq_rdy", int'(claim_rdy), 1);
        checkOutput("noirq_vld_drop", int'(claim_vld), 0);
        checkOutput("noirq_id", int'(id), 5);

        // Completes of ID 0, out-of-range ID and an unclaimed ID.
        complete = 1'b1;
        complete_id = 5'd0;
        @(negedge clk);
        checkOutput("cmp0_rdy", int'(claim_rdy), 1);
        complete_id = 5'd17;
        @(negedge clk);
        checkOutput("cmp17_rdy", int'(claim_rdy), 1);
        complete_id = 5'd6;
        @(negedge clk);
        complete = 1'b0;
`ifdef PLIC_CLAIM_MASK_EN
        checkOutput("cmp_unclaimed_rdy", int'(claim_rdy), 1);
`else
        checkOutput("cmp_unclaimed_rdy", int'(claim_rdy), 0);
`endif
        @(negedge clk);

        // Claim of the best source, then one SETTLE cycle.
        clearSources();
        setSource(3, 2);
        setSource(9, 5);
        threshold = 3'd0;
        @(negedge clk);
        checkOutput("pre_claim_id", int'(id), 10);
        claim = 1'b1;
        @(negedge clk);
        claim = 1'b0;
        checkOutput("claim_vld_pulse", int'(claim_vld), 1);
        checkOutput("claim_id_10", int'(claim_id), 10);
        checkOutput("settle_rdy", int'(claim_rdy), 0);
        checkOutput("settle_ireq", int'(ireq), 0);
        @(negedge clk);
        checkOutput("after_settle_rdy", int'(claim_rdy), 1);
        checkOutput("after_settle_vld", int'(claim_vld), 0);
`ifdef PLIC_CLAIM_MASK_EN
        checkOutput("next_best_id", int'(id), 4);
`else
        checkOutput("next_best_id", int'(id), 10);
`endif

        // Build claimed = {4}, then claim 10 while completing 4.
        claim = 1'b1;
        @(negedge clk);
        claim = 1'b0;
`ifdef PLIC_CLAIM_MASK_EN
        checkOutput("second_claim_id", int'(claim_id), 4);
        @(negedge clk);
        checkOutput("all_claimed_id", int'(id), 0);
`else
        checkOutput("second_claim_id", int'(claim_id), 10);
        @(negedge clk);
        checkOutput("all_claimed_id", int'(id), 10);
`endif
        complete = 1'b1;
        complete_id = 5'd10;
        @(negedge clk);
        complete = 1'b0;
        checkOutput("cmp10_settle_rdy", int'(claim_rdy), 0);
        @(negedge clk);
        checkOutput("cmp10_id", int'(id), 10);
        claim = 1'b1;
        complete = 1'b1;
        complete_id = 5'd4;
        @(negedge clk);
        claim = 1'b0;
        complete = 1'b0;
        checkOutput("both_vld", int'(claim_vld), 1);
        checkOutput("both_cid", int'(claim_id), 10);
        checkOutput("both_settle_rdy", int'(claim_rdy), 0);
        @(negedge clk);
        checkOutput("both_rdy", int'(claim_rdy), 1);
`ifdef PLIC_CLAIM_MASK_EN
        checkOutput("both_id", int'(id), 4);
`else
        checkOutput("both_id", int'(id), 10);
`endif

        // Reset during SETTLE clears everything.
        claim = 1'b1;
        @(negedge clk);
        claim = 1'b0;
        checkOutput("pre_rst_vld", int'(claim_vld), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("settle_rst_vld", int'(claim_vld), 0);
        checkOutput("settle_rst_cid", int'(claim_id), 0);
        checkOutput("settle_rst_id", int'(id), 0);
        checkOutput("settle_rst_ireq", int'(ireq), 0);
        checkOutput("settle_rst_rdy", int'(claim_rdy), 1);
        @(negedge clk);
        checkOutput("post_rst_id", int'(id), 10);

        // Reset coinciding with a claim discards it.
        claim = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        claim = 1'b0;
        rst = 1'b0;
        checkOutput("midclaim_rst_vld", int'(claim_vld), 0);
        checkOutput("midclaim_rst_rdy", int'(claim_rdy), 1);

        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
        end
        @(negedge clk);
        rst = 1'b0;
        claim = 1'b0;
        complete = 1'b0;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
